alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
// - Multi-cycle, parametrised successor to the single-cycle CPU ALU. Keeps its aluc encodings, adds
//   iterative unsigned multiply/divide, registered outputs and a valid/ready handshake.
// - Sits in the EX stage of the multi-cycle/pipelined core. The control unit stalls on in_ready/out_valid.
// PARAMETERS
// - WIDTH         32  operand/result width; power of two, >= 8; SHW = $clog2(WIDTH) is derived
// - ENABLE_MULDIV 1   0: MUL/DIVU decode as illegal (iterative unit not instantiated)
// PORTS
// - clock       in   1      single clock, rising edge
// - reset       in   1      asynchronous, active-high
// - in_valid    in   1      operands/opcode valid
// - in_ready    out  1      block can accept an operation
// - a, b        in   WIDTH  operands
// - aluc        in   4      opcode (alu_pkg constants)
// - out_valid   out  1      result valid, held until out_ready
// - out_ready   in   1      consumer takes result
// - s           out  WIDTH  result (low product / quotient for MUL/DIVU)
// - hi          out  WIDTH  high product / remainder; 0 for other ops
// - z           out  1      s == 0
// - flag_small  out  1      SLT: signed a < b; 0 for every other op (never holds a stale value)
// - div_zero    out  1      DIVU with b == 0
// BEHAVIOUR
// - Opcodes: ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100, PASSB 0010, SLL 0001, SRL 0101,
//   SRA 1101, SLT 1011 (s = a-b, flag_small = sign of signed compare, overflow-correct), MUL 0011, DIVU 1001.
// - Shift amount = b[SHW-1:0]. Upper bits are ignored. SRA replicates a[WIDTH-1].
// - ADD/SUB wrap modulo 2^WIDTH. No overflow trap.
// - Illegal aluc (incl. MUL/DIVU when ENABLE_MULDIV=0): s=0, hi=0, z=1, flags 0, 1-op latency.
// - FSM (alu_pkg state type):
//   IDLE: in_ready=1; on in_valid, latch a/b/aluc;
//         single-cycle op -> DONE; MUL/DIVU -> BUSY, cnt=0.
//   BUSY: one shift-add (MUL) or one restoring-subtract (DIVU) step per cycle;
//         after WIDTH steps -> DONE. in_ready=0.
//   DONE: out_valid=1, outputs stable; when out_ready -> IDLE.
// - Latency (accept edge to out_valid high): 1 cycle for single-cycle ops, WIDTH+1 for MUL/DIVU.
// - Throughput: no accept while in DONE. One result per (latency+1) cycles minimum.
// - in_valid while in_ready=0 is ignored. The source must hold it.
// - DIVU b==0: no iteration; DONE next cycle with s=all-ones, hi=a, div_zero=1.
// - MUL: {hi,s} = a*b unsigned, 2*WIDTH bits exact.
// - Reset (any state, incl. mid-BUSY): state=IDLE, cnt=0. Outputs s,hi=0; z=1; flag_small, div_zero,
//   out_valid = 0; in_ready=1 after reset deasserts. The in-flight op is dropped.
// - All outputs are registered, except in_ready, which decodes from state.
// STRUCTURE
// - alu_pkg: aluc localparams, state enum {IDLE,BUSY,DONE}, is_multicycle(aluc) function.
// - Sub-module alu_muldiv_seq (generate on ENABLE_MULDIV): start/op/a/b in; done/lo/hi/dz out;
//   owns counter and 2*WIDTH accumulator.
// - alu_mc holds the FSM, combinational single-cycle datapath and output registers.
// TESTING
// - WIDTH=32, ADD 0xFFFFFFFF+1 -> s=0, z=1, out_valid 1 cycle after accept.
// - SLT a=0x80000000, b=1 -> flag_small=1. Next op OR 0xF0|0x0F -> s=0xFF, flag_small=0.
// - SRA a=0x80000000, b=0x24 (amt 4) -> s=0xF8000000. SLL same b -> s=0.
// - MUL 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, s=1, out_valid exactly 33 cycles after accept,
//   in_ready=0 throughout.
// - DIVU 100/7 -> s=14, hi=2. DIVU 5/0 -> s=0xFFFFFFFF, hi=5, div_zero=1, 1-cycle latency.
// - Backpressure and reset: hold out_ready=0 for 5 cycles -> result stable, in_valid ignored.
//   Assert reset at BUSY cycle 10 -> IDLE, out_valid=0, next ADD 2+3 gives s=5.
// - Repeat MUL/SRA checks at WIDTH=8 and ENABLE_MULDIV=0 (MUL gives s=0, z=1).

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state type and decode helper for alu_mc
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_PASSB = 4'b0010;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_SLT   = 4'b1011;
    localparam logic [3:0] ALU_MUL   = 4'b0011;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcodes that need the iterative multiply/divide unit
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative shift-add multiplier / restoring divider, one step per cycle
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             dz
);
    localparam int SHW = $clog2(WIDTH);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   dv;
    logic               div_r;
    logic [SHW-1:0]     cnt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;

    // One iteration step; lo/hi expose the post-step value so the last step lands in the output regs directly
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dv} : '0);
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = rem_sh - {1'b0, dv};
        acc_nxt = {sum, acc[WIDTH-1:1]};
        if (div_r) begin
            if (!diff[WIDTH])
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    assign done = run && (cnt == SHW'(WIDTH - 1));
    assign lo   = acc_nxt[WIDTH-1:0];
    assign hi   = acc_nxt[2*WIDTH-1:WIDTH];
    assign dz   = op_div && (b == '0);

    // Load operands on start, then advance one step per running cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            dv    <= '0;
            div_r <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            acc   <= {{WIDTH{1'b0}}, a};
            dv    <= b;
            div_r <= op_div;
            cnt   <= '0;
        end else if (run) begin
            acc   <= acc_nxt;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and registered results
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] hi,
    output logic             z,
    output logic             flag_small,
    output logic             div_zero
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             md_start;
    logic             md_done;
    logic             md_dz;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_hi;
    logic             r_flag;
    logic             r_dz;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && (state == IDLE);
    assign amt      = b[SHW-1:0];
    // A zero divisor short-circuits to a one-cycle result instead of iterating
    assign md_start = accept && (ENABLE_MULDIV != 1'b0) && is_multicycle(aluc) && !md_dz;

    generate
        if (ENABLE_MULDIV) begin : g_md
            alu_muldiv_seq #(.WIDTH(WIDTH)) u_md (
                .clock  (clock),
                .reset  (reset),
                .start  (md_start),
                .run    (state == BUSY),
                .op_div (aluc == ALU_DIVU),
                .a      (a),
                .b      (b),
                .done   (md_done),
                .lo     (md_lo),
                .hi     (md_hi),
                .dz     (md_dz)
            );
        end else begin : g_no_md
            assign md_done = 1'b0;
            assign md_lo   = '0;
            assign md_hi   = '0;
            assign md_dz   = 1'b0;
        end
    endgenerate

    // Single-cycle datapath; unlisted opcodes (and MUL/DIVU without the unit) give all-zero results
    always_comb begin
        r_s    = '0;
        r_hi   = '0;
        r_flag = 1'b0;
        r_dz   = 1'b0;
        case (aluc)
            ALU_ADD:   r_s = a + b;
            ALU_SUB:   r_s = a - b;
            ALU_AND:   r_s = a & b;
            ALU_OR:    r_s = a | b;
            ALU_XOR:   r_s = a ^ b;
            ALU_PASSB: r_s = b;
            ALU_SLL:   r_s = a << amt;
            ALU_SRL:   r_s = a >> amt;
            ALU_SRA:   r_s = $unsigned($signed(a) >>> amt);
            ALU_SLT: begin
                r_s    = a - b;
                r_flag = $signed(a) < $signed(b);
            end
            ALU_DIVU: begin
                if (md_dz) begin
                    r_s  = '1;
                    r_hi = a;
                    r_dz = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)    state_nxt = md_start ? BUSY : DONE;
            BUSY: if (md_done)   state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Result registers: load on single-cycle accept or final iteration, drop valid and flags on consume
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s          <= '0;
            hi         <= '0;
            z          <= 1'b1;
            flag_small <= 1'b0;
            div_zero   <= 1'b0;
            out_valid  <= 1'b0;
        end else if (accept && !md_start) begin
            s          <= r_s;
            hi         <= r_hi;
            z          <= (r_s == '0);
            flag_small <= r_flag;
            div_zero   <= r_dz;
            out_valid  <= 1'b1;
        end else if ((state == BUSY) && md_done) begin
            s          <= md_lo;
            hi         <= md_hi;
            z          <= (md_lo == '0);
            flag_small <= 1'b0;
            div_zero   <= 1'b0;
            out_valid  <= 1'b1;
        end else if ((state == DONE) && out_ready) begin
            flag_small <= 1'b0;
            div_zero   <= 1'b0;
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc at three configurations
module tb_alu_mc;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;

    logic        w_in_ready, w_out_valid, w_z, w_fs, w_dz;
    logic [31:0] w_s, w_hi;
    logic        e_in_ready, e_out_valid, e_z, e_fs, e_dz;
    logic [7:0]  e_s, e_hi;
    logic        n_in_ready, n_out_valid, n_z, n_fs, n_dz;
    logic [31:0] n_s, n_hi;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] s;
        logic [63:0] hi;
        logic        z;
        logic        fs;
        logic        dz;
        int          lat;
    } res_t;

    always #5 clock = ~clock;

    alu_mc #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut_w (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .aluc(aluc), .out_valid(w_out_valid), .out_ready(out_ready),
        .s(w_s), .hi(w_hi), .z(w_z), .flag_small(w_fs), .div_zero(w_dz));

    alu_mc #(.WIDTH(8), .ENABLE_MULDIV(1'b1)) dut_e (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(e_in_ready),
        .a(a[7:0]), .b(b[7:0]), .aluc(aluc), .out_valid(e_out_valid), .out_ready(out_ready),
        .s(e_s), .hi(e_hi), .z(e_z), .flag_small(e_fs), .div_zero(e_dz));

    alu_mc #(.WIDTH(32), .ENABLE_MULDIV(1'b0)) dut_n (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
        .a(a), .b(b), .aluc(aluc), .out_valid(n_out_valid), .out_ready(out_ready),
        .s(n_s), .hi(n_hi), .z(n_z), .flag_small(n_fs), .div_zero(n_dz));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic on masked operands
    function automatic res_t model(input int w, input bit en, input logic [3:0] op,
                                   input logic [31:0] ai, input logic [31:0] bi);
        res_t r;
        longint unsigned full, mask, ua, ub, p;
        longint sa, sb, t;
        int amt;
        full = 64'd1 << w;
        mask = full - 1;
        ua   = ai & mask;
        ub   = bi & mask;
        amt  = int'(ub % w);
        sa   = (ua >= (full >> 1)) ? longint'(ua) - longint'(full) : longint'(ua);
        sb   = (ub >= (full >> 1)) ? longint'(ub) - longint'(full) : longint'(ub);
        r.s = 0; r.hi = 0; r.fs = 0; r.dz = 0; r.lat = 1;
        case (op)
            4'b0000: r.s = (ua + ub) & mask;
            4'b1000: r.s = (ua - ub) & mask;
            4'b0111: r.s = ua & ub;
            4'b0110: r.s = ua | ub;
            4'b0100: r.s = ua ^ ub;
            4'b0010: r.s = ub;
            4'b0001: r.s = (ua << amt) & mask;
            4'b0101: r.s = ua >> amt;
            4'b1101: begin
                t   = sa >>> amt;
                r.s = t & mask;
            end
            4'b1011: begin
                r.s  = (ua - ub) & mask;
                r.fs = (sa < sb);
            end
            4'b0011: if (en) begin
                p     = ua * ub;
                r.s   = p & mask;
                r.hi  = (p >> w) & mask;
                r.lat = w + 1;
            end
            4'b1001: if (en) begin
                if (ub == 0) begin
                    r.s  = mask;
                    r.hi = ua;
                    r.dz = 1;
                end else begin
                    r.s   = ua / ub;
                    r.hi  = ua % ub;
                    r.lat = w + 1;
                end
            end
            default: ;
        endcase
        r.z = (r.s == 0);
        return r;
    endfunction

    task automatic check_res(input string nm, input res_t e, input int lat,
                             input logic [63:0] gs, input logic [63:0] ghi,
                             input logic gz, input logic gfs, input logic gdz);
        chk({nm, "_s"},   gs,  e.s);
        chk({nm, "_hi"},  ghi, e.hi);
        chk({nm, "_z"},   {63'd0, gz},  {63'd0, e.z});
        chk({nm, "_slt"}, {63'd0, gfs}, {63'd0, e.fs});
        chk({nm, "_dz"},  {63'd0, gdz}, {63'd0, e.dz});
        chk({nm, "_lat"}, 64'(lat), 64'(e.lat));
    endtask

    // Issue one op to all three instances in lockstep, measure latency, check, consume
    task automatic run_op(input logic [3:0] op, input logic [31:0] ai, input logic [31:0] bi);
        res_t ew, ee, en;
        int   lw, le, ln, rdy_busy;
        bit   sw, se, sn;
        ew = model(32, 1'b1, op, ai, bi);
        ee = model(8,  1'b1, op, ai, bi);
        en = model(32, 1'b0, op, ai, bi);
        lw = 0; le = 0; ln = 0; rdy_busy = 0;
        sw = 0; se = 0; sn = 0;
        @(negedge clock);
        chk("in_ready_idle", {61'd0, w_in_ready, e_in_ready, n_in_ready}, 64'd7);
        in_valid = 1'b1;
        aluc     = op;
        a        = ai;
        b        = bi;
        for (int k = 0; k < 80 && !(sw && se && sn); k++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (!sw && w_out_valid) begin sw = 1; lw = k + 1; end
            if (!se && e_out_valid) begin se = 1; le = k + 1; end
            if (!sn && n_out_valid) begin sn = 1; ln = k + 1; end
            if (w_in_ready || e_in_ready || n_in_ready) rdy_busy++;
        end
        check_res("w32", ew, lw, {32'd0, w_s}, {32'd0, w_hi}, w_z, w_fs, w_dz);
        check_res("w8",  ee, le, {56'd0, e_s}, {56'd0, e_hi}, e_z, e_fs, e_dz);
        check_res("nomd", en, ln, {32'd0, n_s}, {32'd0, n_hi}, n_z, n_fs, n_dz);
        chk("in_ready_while_busy", 64'(rdy_busy), 64'd0);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("consumed", {61'd0, w_out_valid, e_out_valid, n_out_valid}, 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        aluc = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_s", {32'd0, w_s}, 64'd0);
        chk("rst_hi", {32'd0, w_hi}, 64'd0);
        chk("rst_z", {63'd0, w_z}, 64'd1);
        chk("rst_flags", {62'd0, w_fs, w_dz}, 64'd0);
        chk("rst_out_valid", {61'd0, w_out_valid, e_out_valid, n_out_valid}, 64'd0);
        chk("rst_in_ready", {61'd0, w_in_ready, e_in_ready, n_in_ready}, 64'd7);

        run_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        chk("add_wrap_s", {32'd0, w_s}, 64'd0);
        run_op(ALU_SLT, 32'h8000_0000, 32'd1);
        run_op(ALU_OR, 32'hF0, 32'h0F);
        chk("or_s", {32'd0, w_s}, 64'hFF);
        run_op(ALU_SRA, 32'h8000_0000, 32'h24);
        chk("sra_s", {32'd0, w_s}, 64'hF800_0000);
        run_op(ALU_SLL, 32'h8000_0000, 32'h24);
        run_op(ALU_SRA, 32'h8000_0080, 32'h24);
        run_op(ALU_SRL, 32'h8000_0000, 32'h1F);
        run_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_hi", {32'd0, w_hi}, 64'hFFFF_FFFE);
        chk("mul_s_nomd", {32'd0, n_s}, 64'd0);
        run_op(ALU_DIVU, 32'd100, 32'd7);
        chk("divu_q", {32'd0, w_s}, 64'd14);
        run_op(ALU_DIVU, 32'd5, 32'd0);
        chk("divu0_s", {32'd0, w_s}, 64'hFFFF_FFFF);
        run_op(ALU_SUB, 32'd0, 32'd1);
        run_op(ALU_PASSB, 32'd3, 32'hDEAD_BEEF);
        run_op(ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000);
        run_op(ALU_AND, 32'hA5A5_A5A5, 32'h0FF0_0FF0);
        run_op(4'b1010, 32'h1234_5678, 32'h1);

        // Backpressure: result must hold and a new in_valid must be ignored
        @(negedge clock);
        in_valid = 1'b1; aluc = ALU_ADD; a = 32'd10; b = 32'd20;
        @(negedge clock);
        aluc = ALU_SUB; a = 32'd1; b = 32'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_valid", {63'd0, w_out_valid}, 64'd1);
            chk("bp_s", {32'd0, w_s}, 64'd30);
            chk("bp_in_ready", {63'd0, w_in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("bp_no_extra", {61'd0, w_out_valid, e_out_valid, n_out_valid}, 64'd0);

        // Reset in the middle of an iterative multiply
        in_valid = 1'b1; aluc = ALU_MUL; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (9) @(negedge clock);
        chk("busy_before_rst", {62'd0, w_in_ready, w_out_valid}, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_out_valid", {61'd0, w_out_valid, e_out_valid, n_out_valid}, 64'd0);
        chk("midrst_in_ready", {61'd0, w_in_ready, e_in_ready, n_in_ready}, 64'd7);
        chk("midrst_s", {32'd0, w_s}, 64'd0);
        chk("midrst_z", {63'd0, w_z}, 64'd1);
        run_op(ALU_ADD, 32'd2, 32'd3);
        chk("post_rst_add", {32'd0, w_s}, 64'd5);

        // Random operations, including unlisted opcodes and edge operands
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(0, 40));
                default: rb = $urandom;
            endcase
            run_op(op, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
